// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: state encoding
// and the legal operand-width range.
package seq_mult_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_signed.sv
// Multi-cycle shift-add multiplier, unsigned or two's-complement per operation.
// One (WIDTH+1)-bit adder is reused across WIDTH steps; sign is applied at the end.
module seq_mult_signed
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         dbg_state
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_mult_signed: WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is a request, taken only when the machine is free to
  // begin (IDLE, or the DONE cycle as it hands back to IDLE); busy covers
  // RUN and DONE; done is a one-cycle pulse with p valid during it.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;

    // The most-negative operand's magnitude 2^(WIDTH-1) still fits unsigned.
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    sum  = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    // The {sum, multiplier} pair shifted right by one, i.e. the running product.
    prod = {sum, mplier_q[WIDTH-1:1]};

    case (state_q)
      S_RUN: begin
        acc_d    = {1'b0, sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          p_d     = neg_q ? -prod : prod;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = S_RUN;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign p         = p_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mult_signed.sv
// Bench for seq_mult_signed: directed and random products on WIDTH=4 and
// WIDTH=8 instances, checked against an integer-arithmetic reference.
module tb_seq_mult_signed;

  logic        clk;
  logic        rst_n;

  logic        start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  p4;
  logic [1:0]  st4;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;
  logic [1:0]  st8;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  seq_mult_signed #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4), .dbg_state(st4)
  );

  seq_mult_signed #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8), .dbg_state(st8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer product, truncated to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input logic sm);
    longint ua, ub, r;
    ua = a & ((1 << w) - 1);
    ub = b & ((1 << w) - 1);
    if (sm && ua[w-1]) ua = ua - (64'sd1 << w);
    if (sm && ub[w-1]) ub = ub - (64'sd1 << w);
    r = ua * ub;
    return 16'(r & ((64'sd1 << (2 * w)) - 1));
  endfunction

  // driver tasks
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm, input string tag);
    int n;
    logic [15:0] e;
    exp_q.push_back(ref_mul(4, {4'b0, a}, {4'b0, b}, sm));
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
    @(posedge clk);
    #1 start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); sm4 = 1'($urandom_range(0, 1));
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (done4) break;
    end
    e = exp_q.pop_front();
    if (!done4) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_lat"}, 64'(n), 64'd4);
      chk({tag, "_p"}, 64'(p4), 64'(e[7:0]));
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input string tag);
    int n;
    logic [15:0] e;
    exp_q.push_back(ref_mul(8, a, b, sm));
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1; n++;
      if (done8) break;
    end
    e = exp_q.pop_front();
    if (!done8) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_lat"}, 64'(n), 64'd8);
      chk({tag, "_p"}, 64'(p8), 64'(e));
    end
  endtask

  logic [3:0] ua_t[6] = '{4'd3, 4'd9, 4'd11, 4'd2, 4'd10, 4'd8};
  logic [3:0] ub_t[6] = '{4'd2, 4'd3, 4'd3, 4'd7, 4'd10, 4'd6};
  logic [7:0] up_t[6] = '{8'd6, 8'd27, 8'd33, 8'd14, 8'd100, 8'd48};
  logic [3:0] sa_t[4] = '{4'b1001, 4'b1000, 4'b1000, 4'b1111};
  logic [3:0] sb_t[4] = '{4'b0011, 4'b1000, 4'b0111, 4'b0000};
  logic [7:0] sp_t[4] = '{8'hEB, 8'h40, 8'hC8, 8'h00};

  initial begin
    int bc, dc, d1, d2;
    logic [7:0] pv, pa, pb;

    rst_n = 1'b0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy4", 64'(busy4), 0);
    chk("rst_done4", 64'(done4), 0);
    chk("rst_p4", 64'(p4), 0);
    chk("rst_p8", 64'(p8), 0);
    rst_n = 1'b1;

    // directed unsigned, then signed, cross-checked against the reference too
    for (int i = 0; i < 6; i++) begin
      chk("tbl_u_ref", 64'(ref_mul(4, {4'b0, ua_t[i]}, {4'b0, ub_t[i]}, 1'b0)), 64'(up_t[i]));
      op4(ua_t[i], ub_t[i], 1'b0, "u4");
    end
    for (int i = 0; i < 4; i++) begin
      chk("tbl_s_ref", 64'(ref_mul(4, {4'b0, sa_t[i]}, {4'b0, sb_t[i]}, 1'b1)), 64'(sp_t[i]));
      op4(sa_t[i], sb_t[i], 1'b1, "s4");
    end

    // start while busy must be ignored
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd5; sm4 = 1'b0;
    @(posedge clk);
    bc = 0; dc = 0; pv = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      start4 = (i == 2);
      if (i == 2) begin a4 = 4'd15; b4 = 4'd15; end
      if (busy4) bc++;
      if (done4) begin dc++; pv = p4; end
      @(posedge clk);
    end
    #1 start4 = 1'b0;
    chk("hs_dones", 64'(dc), 1);
    chk("hs_p", 64'(pv), 25);
    chk("hs_busy_cycles", 64'(bc), 5);

    // asynchronous reset mid-operation
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy4), 0);
    chk("arst_done", 64'(done4), 0);
    chk("arst_p", 64'(p4), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) dc++;
    end
    chk("arst_no_done", 64'(dc), 0);
    op4(4'd7, 4'd7, 1'b0, "after_rst");

    // back-to-back with start held high
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd4; b4 = 4'd4; sm4 = 1'b0;
    @(posedge clk);
    dc = 0; d1 = -1; d2 = -1; pa = '0; pb = '0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (i == 0) begin a4 = 4'd6; b4 = 4'd6; end
      if (done4) begin
        dc++;
        if (dc == 1) begin d1 = i; pa = p4; end
        if (dc == 2) begin d2 = i; pb = p4; start4 = 1'b0; end
      end
      @(posedge clk);
    end
    #1 start4 = 1'b0;
    chk("b2b_dones", 64'(dc), 2);
    chk("b2b_first_lat", 64'(d1), 4);
    chk("b2b_gap", 64'(d2 - d1), 5);
    chk("b2b_p1", 64'(pa), 16);
    chk("b2b_p2", 64'(pb), 36);

    // WIDTH=8 boundaries
    op8(8'd255, 8'd255, 1'b0, "w8_u_max");
    op8(8'h80, 8'h80, 1'b1, "w8_s_min");

    // random stimulus on both widths
    for (int i = 0; i < 40; i++)
      op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd4");
    for (int i = 0; i < 12; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd8");

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
